// File: rtl/branch_pkg.sv
// Shared types and constants for the branch unit: condition codes, FSM states
// and the flag-based condition evaluator.
package branch_pkg;

  localparam int LUT_DEPTH = 16;
  localparam int ADDR_W    = 10;
  localparam int LC_W      = 8;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_N      = 3'd3,
    COND_NN     = 3'd4,
    COND_C      = 3'd5,
    COND_NC     = 3'd6,
    COND_DJNZ   = 3'd7
  } cond_e;

  typedef enum logic {
    BU_LOAD = 1'b0,
    BU_RUN  = 1'b1
  } bu_state_e;

  // DJNZ is not a flag condition; the loop counter logic resolves it.
  function automatic logic flag_cond(input cond_e c, input logic z, input logic n,
                                     input logic cy);
    logic res;
    res = 1'b0;
    case (c)
      COND_ALWAYS: res = 1'b1;
      COND_Z:      res = z;
      COND_NZ:     res = !z;
      COND_N:      res = n;
      COND_NN:     res = !n;
      COND_C:      res = cy;
      COND_NC:     res = !cy;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jump_lut.sv
// Jump-target register file: one write port, asynchronous read port.
// Entries not written since the last clear read as zero; storage itself is never reset.
module jump_lut #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata = r_valid[i_raddr] ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/branch_unit.sv
// Jump/skip resolver feeding the PC stage. Optional hardware loop counter
// (DJNZ, cond 7) is enabled with `define BRANCH_LOOP_CNT_EN.
module branch_unit #(
  parameter int LUT_DEPTH = branch_pkg::LUT_DEPTH,
  parameter int ADDR_W    = branch_pkg::ADDR_W
) (
  input  logic                         clk,
  input  logic                         init,
  input  logic                         lut_valid,
  output logic                         lut_ready,
  input  logic [ADDR_W-1:0]            lut_data,
  input  logic                         is_jump,
  input  logic                         is_skip,
  input  logic [2:0]                   cond,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_idx,
  input  logic                         flag_we,
  input  logic                         z_in,
  input  logic                         n_in,
  input  logic                         c_in,
  input  logic                         lc_we,
  input  logic [7:0]                   lc_data,
  output logic                         jump_en,
  output logic                         branch_taken,
  output logic                         branch_skip,
  output logic [ADDR_W-1:0]            jump_addr,
  output logic                         stall
);

  import branch_pkg::*;

  localparam int IDX_W = $clog2(LUT_DEPTH);

  bu_state_e        r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_z;
  logic             r_n;
  logic             r_c;

  logic  w_run;
  logic  w_lut_we;
  logic  w_cond_true;
  cond_e w_cond;

  assign w_cond   = cond_e'(cond);
  assign w_run    = (r_state == BU_RUN);
  assign w_lut_we = !w_run && lut_valid && !init;

  always_ff @(posedge clk) begin
    if (init) begin
      r_state <= BU_LOAD;
      r_ptr   <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_c     <= 1'b0;
    end else if (!w_run) begin
      if (lut_valid) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_ptr == IDX_W'(LUT_DEPTH - 1)) begin
          r_state <= BU_RUN;
        end
      end
    end else if (flag_we) begin
      r_z <= z_in;
      r_n <= n_in;
      r_c <= c_in;
    end
  end

`ifdef BRANCH_LOOP_CNT_EN
  logic [LC_W-1:0] r_lc;
  logic            w_djnz_jump;

  // A counter load in the same cycle pre-empts the DJNZ entirely.
  assign w_djnz_jump = w_run && is_jump && (w_cond == COND_DJNZ) && !lc_we;

  always_ff @(posedge clk) begin
    if (init) begin
      r_lc <= '0;
    end else if (lc_we) begin
      r_lc <= lc_data;
    end else if (w_djnz_jump && (r_lc != '0)) begin
      r_lc <= r_lc - 1'b1;
    end
  end

  // Taken when the post-decrement value is nonzero, i.e. the counter is above 1.
  assign w_cond_true = (w_cond == COND_DJNZ) ? (!lc_we && (r_lc > LC_W'(1)))
                                             : flag_cond(w_cond, r_z, r_n, r_c);
`else
  logic w_unused_lc;

  assign w_unused_lc = ^{lc_we, lc_data};
  assign w_cond_true = flag_cond(w_cond, r_z, r_n, r_c);
`endif

  assign jump_en      = w_run && is_jump && w_cond_true;
  assign branch_skip  = w_run && is_skip && w_cond_true && !is_jump;
  assign branch_taken = jump_en || branch_skip;
  assign lut_ready    = !w_run;
  assign stall        = !w_run;

  jump_lut #(
    .DEPTH (LUT_DEPTH),
    .WIDTH (ADDR_W),
    .IDX_W (IDX_W)
  ) u_jump_lut (
    .clk     (clk),
    .i_clr   (init),
    .i_we    (w_lut_we),
    .i_waddr (r_ptr),
    .i_wdata (lut_data),
    .i_raddr (lut_idx),
    .o_rdata (jump_addr)
  );

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed test-plan steps plus randomized
// RUN traffic, checked against a behavioural model of the jump/skip rules.
module tb_branch_unit;

`ifdef BRANCH_LOOP_CNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       lut_valid = 1'b0;
  logic       lut_ready;
  logic [9:0] lut_data = '0;
  logic       is_jump = 1'b0;
  logic       is_skip = 1'b0;
  logic [2:0] cond = '0;
  logic [3:0] lut_idx = '0;
  logic       flag_we = 1'b0;
  logic       z_in = 1'b0;
  logic       n_in = 1'b0;
  logic       c_in = 1'b0;
  logic       lc_we = 1'b0;
  logic [7:0] lc_data = '0;
  logic       jump_en;
  logic       branch_taken;
  logic       branch_skip;
  logic [9:0] jump_addr;
  logic       stall;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit m_run;
  int m_ptr;
  int m_lut [16];
  bit m_written [16];
  bit m_z, m_n, m_c;
  int m_lc;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk          (clk),
    .init         (init),
    .lut_valid    (lut_valid),
    .lut_ready    (lut_ready),
    .lut_data     (lut_data),
    .is_jump      (is_jump),
    .is_skip      (is_skip),
    .cond         (cond),
    .lut_idx      (lut_idx),
    .flag_we      (flag_we),
    .z_in         (z_in),
    .n_in         (n_in),
    .c_in         (c_in),
    .lc_we        (lc_we),
    .lc_data      (lc_data),
    .jump_en      (jump_en),
    .branch_taken (branch_taken),
    .branch_skip  (branch_skip),
    .jump_addr    (jump_addr),
    .stall        (stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_cond();
    case (cond)
      3'd0: return 1'b1;
      3'd1: return m_z;
      3'd2: return !m_z;
      3'd3: return m_n;
      3'd4: return !m_n;
      3'd5: return m_c;
      3'd6: return !m_c;
      default: return LC_EN && !lc_we && (m_lc != 0) && ((m_lc - 1) != 0);
    endcase
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_ptr = 0;
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    m_lc = 0;
    for (int i = 0; i < 16; i++) m_written[i] = 1'b0;
  endtask

  task automatic model_edge();
    if (init) begin
      model_reset();
    end else begin
      if (!m_run) begin
        if (lut_valid) begin
          m_lut[m_ptr] = int'(lut_data);
          m_written[m_ptr] = 1'b1;
          m_ptr++;
          if (m_ptr == 16) m_run = 1'b1;
        end
      end else if (flag_we) begin
        m_z = z_in; m_n = n_in; m_c = c_in;
      end
      if (LC_EN) begin
        if (lc_we) m_lc = int'(lc_data);
        else if (m_run && is_jump && cond == 3'd7 && m_lc > 0) m_lc = m_lc - 1;
      end
    end
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance the model.
  task automatic step();
    bit       c_true, e_jump, e_skip;
    int       e_addr;
    @(negedge clk);
    c_true = model_cond();
    e_jump = m_run && is_jump && c_true;
    e_skip = m_run && is_skip && c_true && !is_jump;
    e_addr = m_written[lut_idx] ? m_lut[lut_idx] : 0;
    $display("t=%0t init=%0b run=%0b j=%0b s=%0b cond=%0d idx=%0d -> jump_en=%0b skip=%0b taken=%0b addr=%0h stall=%0b",
             $time, init, m_run, is_jump, is_skip, cond, lut_idx,
             jump_en, branch_skip, branch_taken, jump_addr, stall);
    check("jump_en", 32'(jump_en), 32'(e_jump));
    check("branch_skip", 32'(branch_skip), 32'(e_skip));
    check("branch_taken", 32'(branch_taken), 32'(e_jump || e_skip));
    check("jump_addr", 32'(jump_addr), 32'(e_addr));
    check("stall", 32'(stall), 32'(!m_run));
    check("lut_ready", 32'(lut_ready), 32'(!m_run));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_run_inputs();
    init      = 1'b0;
    lut_valid = 1'($urandom_range(0, 1));
    lut_data  = 10'($urandom);
    is_jump   = 1'($urandom_range(0, 1));
    is_skip   = 1'($urandom_range(0, 1));
    cond      = 3'($urandom_range(0, 7));
    lut_idx   = 4'($urandom_range(0, 15));
    flag_we   = 1'($urandom_range(0, 1));
    z_in      = 1'($urandom_range(0, 1));
    n_in      = 1'($urandom_range(0, 1));
    c_in      = 1'($urandom_range(0, 1));
    lc_we     = ($urandom_range(0, 7) == 0);
    lc_data   = 8'($urandom_range(0, 5));
  endtask

  initial begin
    int n;
    model_reset();
    for (int i = 0; i < 16; i++) m_lut[i] = 0;

    // Unchecked settling cycles under reset, then reset state checks with a jump requested
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    init = 1'b1; is_jump = 1'b1; is_skip = 1'b1; cond = 3'd0; lut_idx = 4'd5;
    #1;
    check("reset_stall", 32'(stall), 32'd1);
    check("reset_ready", 32'(lut_ready), 32'd1);
    check("reset_jump_forced", 32'(jump_en), 32'd0);
    step();

    // Stream 16 targets; each entry reads 0 until the edge that writes it
    init = 1'b0;
    is_skip = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lut_valid = 1'b1;
      lut_data  = 10'(32'h100 + i);
      lut_idx   = 4'(i);
      #1;
      check("load_stall", 32'(stall), 32'd1);
      check("load_unwritten_addr", 32'(jump_addr), 32'd0);
      step();
    end
    lut_valid = 1'b1; lut_data = 10'h3ff; is_jump = 1'b0;
    #1;
    check("run_stall", 32'(stall), 32'd0);
    check("run_ready", 32'(lut_ready), 32'd0);
    repeat (3) step();
    lut_valid = 1'b0;

    // Flag timing: a jump in the flag-write cycle sees the old flags
    flag_we = 1'b1; z_in = 1'b1; n_in = 1'b0; c_in = 1'b0;
    is_jump = 1'b1; cond = 3'd1; lut_idx = 4'd3;
    #1;
    check("flag_same_cycle_jump", 32'(jump_en), 32'd0);
    step();
    flag_we = 1'b0;
    #1;
    check("flag_next_cycle_jump", 32'(jump_en), 32'd1);
    check("flag_next_cycle_addr", 32'(jump_addr), 32'h103);
    step();

    // Skip on N / !N
    is_jump = 1'b0; flag_we = 1'b1; z_in = 1'b0; n_in = 1'b1; c_in = 1'b0;
    step();
    flag_we = 1'b0; is_skip = 1'b1; cond = 3'd3;
    #1;
    check("skip_n", 32'(branch_skip), 32'd1);
    check("skip_n_taken", 32'(branch_taken), 32'd1);
    step();
    cond = 3'd4;
    #1;
    check("skip_nn", 32'(branch_skip), 32'd0);
    check("skip_nn_taken", 32'(branch_taken), 32'd0);
    step();

    // Jump wins over skip
    is_jump = 1'b1; is_skip = 1'b1; cond = 3'd0;
    #1;
    check("both_jump", 32'(jump_en), 32'd1);
    check("both_skip", 32'(branch_skip), 32'd0);
    step();

    // DJNZ sequence: load 3, then four DJNZ
    is_jump = 1'b0; is_skip = 1'b0; lc_we = 1'b1; lc_data = 8'd3;
    step();
    lc_we = 1'b0; is_jump = 1'b1; cond = 3'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("djnz_seq", 32'(jump_en), 32'(LC_EN && k < 2));
      step();
    end
    lc_we = 1'b1; lc_data = 8'd5;
    #1;
    check("djnz_load_wins", 32'(jump_en), 32'd0);
    step();
    lc_we = 1'b0;
    #1;
    check("djnz_after_load", 32'(jump_en), 32'(LC_EN));
    step();

    // Randomized RUN traffic
    for (int r = 0; r < 150; r++) begin
      randomize_run_inputs();
      step();
    end

    // Reset mid-RUN, reload with gaps in lut_valid
    randomize_run_inputs();
    init = 1'b1; is_jump = 1'b1; cond = 3'd0;
    step();
    init = 1'b0; is_skip = 1'b1; flag_we = 1'b0; lc_we = 1'b0;
    n = 0;
    while (m_run == 1'b0 && n < 200) begin
      lut_valid = 1'($urandom_range(0, 1));
      lut_data  = 10'(32'h200 + m_ptr);
      lut_idx   = 4'($urandom_range(0, 15));
      #1;
      check("reload_stall", 32'(stall), 32'd1);
      check("reload_jump_forced", 32'(jump_en), 32'd0);
      step();
      n++;
    end
    #1;
    check("reload_done", 32'(stall), 32'd0);
    lut_idx = 4'd7; is_jump = 1'b0; is_skip = 1'b0;
    #1;
    check("reload_addr7", 32'(jump_addr), 32'h207);
    for (int r = 0; r < 30; r++) begin
      randomize_run_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Resolves jump and skip decisions for the program counter each cycle. Sits directly upstream of the PC stage and drives its `jump_en`, `branch_taken`, `branch_skip`, `jump_addr` and `halt` inputs. Holds a 16-entry jump-target table loaded after reset, a registered ALU flag set, and an optional hardware loop counter.

## Interface
- `LUT_DEPTH`, 16: number of jump-target entries; index width is log2.
- `ADDR_W`, 10: instruction address width; must match the PC.
- `clk` in 1: single clock; all state updates on the posedge.
- `init` in 1: synchronous, active-high reset, sampled on the posedge.
- `lut_valid` in 1: a load word is present on `lut_data`.
- `lut_ready` out 1: the table accepts a word this cycle.
- `lut_data` in ADDR_W: jump target being loaded.
- `is_jump` in 1: current instruction is a conditional jump.
- `is_skip` in 1: current instruction is a conditional skip.
- `cond` in 3: condition code (see Operation).
- `lut_idx` in 4: table index for a jump target.
- `flag_we` in 1: capture `z_in`, `n_in` and `c_in` at the end of this cycle.
- `z_in`, `n_in`, `c_in` in 1 each: ALU zero, negative and carry flags.
- `lc_we` in 1: load the loop counter (only with the macro).
- `lc_data` in 8: loop counter load value (only with the macro).
- `jump_en` out 1: PC loads `jump_addr` next edge.
- `branch_taken` out 1: the jump or skip condition evaluated true.
- `branch_skip` out 1: PC advances by 2.
- `jump_addr` out ADDR_W: the table entry at `lut_idx`.
- `stall` out 1: drives the PC's `halt` input.

## Operation
- States: LOAD and RUN. `init` enters LOAD with the write pointer at 0 and flags at 0.
- LOAD behaviour:
  - `lut_ready`=1 and `stall`=1.
  - Each `lut_valid`&&`lut_ready` writes `lut_data` to entry[ptr] and increments ptr.
  - Accepting entry LUT_DEPTH-1 moves the block to RUN on the same edge.
  - `jump_en`, `branch_skip` and `branch_taken` are forced to 0.
- RUN behaviour: `lut_ready`=0 and `stall`=0; `lut_valid` is ignored.
- Condition codes:
  - 0: always. 1: Z. 2: !Z. 3: N. 4: !N. 5: C. 6: !C.
  - 7: DJNZ (decrement and jump if not zero), only with the macro.
- Flags used for conditions are the registered copies, not `z_in`, `n_in` or `c_in` directly.
- Outputs in RUN:
  - `jump_en` = `is_jump` && condition true.
  - `branch_skip` = `is_skip` && condition true && !`is_jump`. Jump wins if both are asserted.
  - `branch_taken` = `jump_en` || `branch_skip`.
- `jump_addr` = entry[`lut_idx`] at all times, including in LOAD. Entries not yet written read as 0.
- Flags register: updated on `flag_we` in RUN; ignored in LOAD.
- `init` during LOAD or RUN restarts LOAD. The table contents are not cleared, but ptr resets to 0 and every entry is rewritten.

## Timing
- Reset values: `lut_ready`=1, `stall`=1, `jump_en`=0, `branch_skip`=0, `branch_taken`=0, `jump_addr`=entry[`lut_idx`].
- Decision outputs are combinational from the current inputs plus registered state. The PC consumes them at the same edge, so a jump has zero added latency.
- Flags written with `flag_we` in cycle N are visible to conditions in cycle N+1. A jump in cycle N sees the old flags.
- Load throughput: one word per cycle. The minimum time from `init` deassertion to RUN is LUT_DEPTH cycles.
- The cycle that accepts the last word still has `stall`=1. `stall` drops in the following cycle.

## Configuration
- `BRANCH_LOOP_CNT_EN` defined:
  - Adds an 8-bit loop counter, reset to 0; `lc_we` loads `lc_data`.
  - Cond 7 with `is_jump`: the counter decrements at the edge, and the jump is taken if the decremented value is nonzero.
  - If the counter is already 0, it stays 0 and the jump is not taken.
  - `lc_we` and DJNZ in the same cycle: the load wins and no jump is taken.
- Not defined: the counter is absent and `lc_we`/`lc_data` are ignored. Cond 7 evaluates false.

## Structure
- Shared package `branch_pkg`:
  - cond enum `cond_e` (COND_ALWAYS … COND_DJNZ).
  - `LUT_DEPTH`, `ADDR_W` constants.
  - state enum `bu_state_e` {BU_LOAD, BU_RUN}.
- One sub-module, `jump_lut`: a LUT_DEPTH×ADDR_W register file with one write port and an asynchronous read port.

## Test plan
- Reset and load: assert `init`, then stream targets 0x100+i for i=0..15 with `lut_valid` held high. `stall` reads 1 for 16 cycles, then 0; `lut_ready`=0 in RUN.
- Flag timing: `flag_we` with z=1 and, in the same cycle, `is_jump` cond=1 → `jump_en`=0. Next cycle, cond=1 with `lut_idx`=3 → `jump_en`=1, `jump_addr`=0x103.
- Skip: N=1, `is_skip` cond=3 → `branch_skip`=1, `branch_taken`=1. With cond=4 → both 0.
- Jump and skip both asserted with cond=0 → `jump_en`=1, `branch_skip`=0.
- DJNZ (macro on): load counter=3, then issue DJNZ four times → taken, taken, not taken, not taken; the counter ends at 0. With the macro off → never taken.
- Reset mid-RUN: `init` → LOAD, `stall`=1, and outputs are 0 until 16 new words are loaded.
